// File: rtl/nv_nvdla_sdp_nrdma_pkg.sv
// Shared constants and FSM encoding for the SDP NRDMA ingress read path.
// Imported by the read-request generator and its helpers.
package nv_nvdla_sdp_nrdma_pkg;

    localparam int ATOM_LOG2       = 5;
    localparam int DMA_RD_REQ_PD_W = 64 + 15;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

endpackage

// File: rtl/nv_nvdla_sdp_nrdma_credit_cnt.sv
// Response-buffer credit counter: subtracts on request load, adds one per popped atom.
// A return with the counter already full and nothing loading is dropped and flagged sticky.
module nv_nvdla_sdp_nrdma_credit_cnt #(
    parameter int DEPTH = 256,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             dec_en_i,
    input  logic [CNT_W-1:0] dec_amt_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             err_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // A load always leaves room for a same-cycle return, so only the no-load path can overflow.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (dec_en_i) begin
            cnt_d = cnt_q - dec_amt_i + CNT_W'(inc_i);
        end else if (inc_i) begin
            if (cnt_q == CNT_W'(DEPTH)) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= CNT_W'(DEPTH);
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = err_q;

endmodule

// File: rtl/nv_nvdla_sdp_nrdma_ig_rd_req.sv
// SDP NRDMA ingress read-request generator: splits one atom-range command into
// window-aligned DMA read bursts, each gated on free response-buffer credits.
module nv_nvdla_sdp_nrdma_ig_rd_req #(
    parameter  int ADDR_W       = 64,
    parameter  int SIZE_W       = 15,
    parameter  int ATOM_LOG2    = nv_nvdla_sdp_nrdma_pkg::ATOM_LOG2,
    parameter  int MAX_BURST    = 8,
    parameter  int CREDIT_DEPTH = 256,
    localparam int CNT_W        = $clog2(CREDIT_DEPTH) + 1
) (
    input  logic                     nvdla_core_clk,
    input  logic                     nvdla_core_rst,
    input  logic                     cmd_vld,
    output logic                     cmd_rdy,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [SIZE_W-1:0]        cmd_size,
    output logic                     dma_rd_req_vld,
    input  logic                     dma_rd_req_rdy,
    output logic [ADDR_W+SIZE_W-1:0] dma_rd_req_pd,
    input  logic                     rsp_credit_ret,
    output logic [CNT_W-1:0]         credit_cnt,
    output logic                     credit_err,
    output logic                     idle
);

    import nv_nvdla_sdp_nrdma_pkg::*;

    localparam int MB_LOG2 = $clog2(MAX_BURST);
    localparam int BURST_W = MB_LOG2 + 1;
    localparam int REM_W   = SIZE_W + 1;
    localparam int PD_W    = ADDR_W + SIZE_W;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
    logic [REM_W-1:0]   remain_q, remain_d;
    logic               req_vld_q, req_vld_d;
    logic [PD_W-1:0]    req_pd_q, req_pd_d;

    logic [MB_LOG2-1:0] win_off;
    logic [BURST_W-1:0] window;
    logic [BURST_W-1:0] burst;
    logic               slot_free;
    logic               credit_ok;
    logic               load;
    logic [ATOM_LOG2-1:0] addr_lsb_unused;

    assign addr_lsb_unused = cmd_addr[ATOM_LOG2-1:0];

    // Atoms left before the next MAX_BURST-aligned boundary caps the burst.
    assign win_off   = cur_addr_q[ATOM_LOG2 +: MB_LOG2];
    assign window    = BURST_W'(MAX_BURST) - BURST_W'(win_off);
    assign burst     = (remain_q < REM_W'(window)) ? BURST_W'(remain_q) : window;
    assign slot_free = !req_vld_q || dma_rd_req_rdy;
    assign credit_ok = credit_cnt >= CNT_W'(burst);
    assign load      = (state_q == ISSUE) && slot_free && credit_ok;

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        remain_d   = remain_q;
        req_vld_d  = req_vld_q;
        req_pd_d   = req_pd_q;

        if (req_vld_q && dma_rd_req_rdy) begin
            req_vld_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cmd_vld) begin
                    cur_addr_d = {cmd_addr[ADDR_W-1:ATOM_LOG2], {ATOM_LOG2{1'b0}}};
                    remain_d   = REM_W'(cmd_size) + REM_W'(1);
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (load) begin
                    req_vld_d  = 1'b1;
                    req_pd_d   = {SIZE_W'(burst - BURST_W'(1)), cur_addr_q};
                    cur_addr_d = cur_addr_q + (ADDR_W'(burst) << ATOM_LOG2);
                    remain_d   = remain_q - REM_W'(burst);
                    if (remain_q == REM_W'(burst)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            remain_q   <= '0;
            req_vld_q  <= 1'b0;
            req_pd_q   <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            remain_q   <= remain_d;
            req_vld_q  <= req_vld_d;
            req_pd_q   <= req_pd_d;
        end
    end

    nv_nvdla_sdp_nrdma_credit_cnt #(
        .DEPTH (CREDIT_DEPTH),
        .CNT_W (CNT_W)
    ) u_credit_cnt (
        .clk_i     (nvdla_core_clk),
        .rst_i     (nvdla_core_rst),
        .dec_en_i  (load),
        .dec_amt_i (CNT_W'(burst)),
        .inc_i     (rsp_credit_ret),
        .cnt_o     (credit_cnt),
        .err_o     (credit_err)
    );

    assign cmd_rdy        = (state_q == IDLE);
    assign dma_rd_req_vld = req_vld_q;
    assign dma_rd_req_pd  = req_pd_q;
    assign idle           = (state_q == IDLE) && !req_vld_q && (credit_cnt == CNT_W'(CREDIT_DEPTH));

endmodule

// File: tb/tb_nv_nvdla_sdp_nrdma_ig_rd_req.sv
// Directed bench for the NRDMA read-request generator: a default instance and a
// second instance with an 8-atom credit pool for the credit-stall case.
module tb_nv_nvdla_sdp_nrdma_ig_rd_req;

    logic        clock = 1'b0;
    logic        reset;

    logic        cmdVldA, cmdRdyA, vldA, rdyA, retA, errA, idleA;
    logic [63:0] addrA;
    logic [14:0] sizeA;
    logic [78:0] pdA;
    logic [8:0]  creditA;

    logic        cmdVldB, cmdRdyB, vldB, rdyB, retB, errB, idleB;
    logic [63:0] addrB;
    logic [14:0] sizeB;
    logic [78:0] pdB;
    logic [3:0]  creditB;

    int checkCount = 0;
    int failCount  = 0;

    always #5 clock = ~clock;

    nv_nvdla_sdp_nrdma_ig_rd_req dutA (
        .nvdla_core_clk (clock),
        .nvdla_core_rst (reset),
        .cmd_vld        (cmdVldA),
        .cmd_rdy        (cmdRdyA),
        .cmd_addr       (addrA),
        .cmd_size       (sizeA),
        .dma_rd_req_vld (vldA),
        .dma_rd_req_rdy (rdyA),
        .dma_rd_req_pd  (pdA),
        .rsp_credit_ret (retA),
        .credit_cnt     (creditA),
        .credit_err     (errA),
        .idle           (idleA)
    );

    nv_nvdla_sdp_nrdma_ig_rd_req #(.CREDIT_DEPTH(8)) dutB (
        .nvdla_core_clk (clock),
        .nvdla_core_rst (reset),
        .cmd_vld        (cmdVldB),
        .cmd_rdy        (cmdRdyB),
        .cmd_addr       (addrB),
        .cmd_size       (sizeB),
        .dma_rd_req_vld (vldB),
        .dma_rd_req_rdy (rdyB),
        .dma_rd_req_pd  (pdB),
        .rsp_credit_ret (retB),
        .credit_cnt     (creditB),
        .credit_err     (errB),
        .idle           (idleB)
    );

    function automatic logic [78:0] reqPd(input int atomsMinus1, input logic [63:0] addr);
        return {15'(atomsMinus1), addr};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one command for a single clock; returns at the negedge after acceptance.
    task automatic applyStimulus(input bit useB, input logic [63:0] addr, input logic [14:0] size);
        if (useB) begin
            cmdVldB = 1'b1; addrB = addr; sizeB = size;
        end else begin
            cmdVldA = 1'b1; addrA = addr; sizeA = size;
        end
        @(negedge clock);
        cmdVldA = 1'b0;
        cmdVldB = 1'b0;
    endtask

    task automatic returnCredits(input bit useB, input int n);
        for (int i = 0; i < n; i++) begin
            if (useB) retB = 1'b1; else retA = 1'b1;
            @(negedge clock);
        end
        retA = 1'b0;
        retB = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        cmdVldA = 1'b0; addrA = '0; sizeA = '0; rdyA = 1'b1; retA = 1'b0;
        cmdVldB = 1'b0; addrB = '0; sizeB = '0; rdyB = 1'b1; retB = 1'b0;
        repeat (2) @(negedge clock);

        checkOutput("rst_vld",    vldA,    0);
        checkOutput("rst_pd",     pdA,     0);
        checkOutput("rst_cmdrdy", cmdRdyA, 1);
        checkOutput("rst_credit", creditA, 256);
        checkOutput("rst_err",    errA,    0);
        checkOutput("rst_idle",   idleA,   1);
        checkOutput("rst_creditB", creditB, 8);
        reset = 1'b0;
        @(negedge clock);

        // Aligned 8-atom command fits one burst.
        applyStimulus(0, 64'h1000_0000, 15'd7);
        checkOutput("t1_cmdrdy_issue", cmdRdyA, 0);
        checkOutput("t1_vld_lat1",     vldA,    0);
        @(negedge clock);
        checkOutput("t1_vld",    vldA,    1);
        checkOutput("t1_pd",     pdA,     reqPd(7, 64'h1000_0000));
        checkOutput("t1_credit", creditA, 248);
        checkOutput("t1_cmdrdy", cmdRdyA, 1);
        @(negedge clock);
        checkOutput("t1_vld_drop", vldA,  0);
        checkOutput("t1_notidle",  idleA, 0);
        returnCredits(0, 8);
        checkOutput("t1_credit_back", creditA, 256);
        checkOutput("t1_idle",        idleA,   1);

        // Start two atoms into a window: 6-atom then 4-atom burst.
        applyStimulus(0, 64'h1000_0040, 15'd9);
        @(negedge clock);
        checkOutput("t2_pd0",     pdA,     reqPd(5, 64'h1000_0040));
        checkOutput("t2_credit0", creditA, 250);
        checkOutput("t2_cmdrdy0", cmdRdyA, 0);
        @(negedge clock);
        checkOutput("t2_vld1",    vldA,    1);
        checkOutput("t2_pd1",     pdA,     reqPd(3, 64'h1000_0100));
        checkOutput("t2_credit1", creditA, 246);
        checkOutput("t2_cmdrdy1", cmdRdyA, 1);
        @(negedge clock);
        checkOutput("t2_vld_drop", vldA, 0);
        returnCredits(0, 9);
        checkOutput("t2_idle_9", idleA, 0);
        returnCredits(0, 1);
        checkOutput("t2_idle_10", idleA, 1);

        // Backpressure on a 16-atom command.
        rdyA = 1'b0;
        applyStimulus(0, 64'h0, 15'd15);
        @(negedge clock);
        checkOutput("t3_pd0",     pdA,     reqPd(7, 64'h0));
        checkOutput("t3_credit0", creditA, 248);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("t3_hold_vld",    vldA,    1);
            checkOutput("t3_hold_pd",     pdA,     reqPd(7, 64'h0));
            checkOutput("t3_hold_credit", creditA, 248);
        end
        rdyA = 1'b1;
        @(negedge clock);
        checkOutput("t3_vld1",    vldA,    1);
        checkOutput("t3_pd1",     pdA,     reqPd(7, 64'h100));
        checkOutput("t3_credit1", creditA, 240);
        @(negedge clock);
        checkOutput("t3_vld_drop", vldA, 0);
        returnCredits(0, 16);
        checkOutput("t3_idle", idleA, 1);

        // Return while already full, then return alongside a 4-atom load.
        retA = 1'b1;
        @(negedge clock);
        retA = 1'b0;
        checkOutput("t5_full_credit", creditA, 256);
        checkOutput("t5_err",         errA,    1);
        applyStimulus(0, 64'h0, 15'd3);
        retA = 1'b1;
        @(negedge clock);
        retA = 1'b0;
        checkOutput("t5_load_ret_credit", creditA, 253);
        checkOutput("t5_load_pd",         pdA,     reqPd(3, 64'h0));
        @(negedge clock);
        returnCredits(0, 3);
        checkOutput("t5_credit_back", creditA, 256);
        checkOutput("t5_err_sticky",  errA,    1);

        // Eight-credit pool: second command stalls until all credits come back.
        applyStimulus(1, 64'h0, 15'd7);
        @(negedge clock);
        checkOutput("t4_pd0",     pdB,     reqPd(7, 64'h0));
        checkOutput("t4_credit0", creditB, 0);
        applyStimulus(1, 64'h100, 15'd7);
        checkOutput("t4_stall_vld",    vldB,    0);
        checkOutput("t4_stall_cmdrdy", cmdRdyB, 0);
        returnCredits(1, 7);
        checkOutput("t4_vld_7",    vldB,    0);
        checkOutput("t4_credit_7", creditB, 7);
        returnCredits(1, 1);
        checkOutput("t4_vld_8",    vldB,    0);
        checkOutput("t4_credit_8", creditB, 8);
        @(negedge clock);
        checkOutput("t4_vld1",    vldB,    1);
        checkOutput("t4_pd1",     pdB,     reqPd(7, 64'h100));
        checkOutput("t4_credit1", creditB, 0);
        @(negedge clock);
        returnCredits(1, 8);
        checkOutput("t4_idle", idleB, 1);

        // Reset in the middle of a transfer with a request outstanding.
        rdyA = 1'b0;
        applyStimulus(0, 64'h0, 15'd15);
        @(negedge clock);
        checkOutput("t6_pre_vld",    vldA,    1);
        checkOutput("t6_pre_cmdrdy", cmdRdyA, 0);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("t6_vld",    vldA,    0);
        checkOutput("t6_pd",     pdA,     0);
        checkOutput("t6_cmdrdy", cmdRdyA, 1);
        checkOutput("t6_credit", creditA, 256);
        checkOutput("t6_idle",   idleA,   1);
        checkOutput("t6_err",    errA,    0);
        reset = 1'b0;
        rdyA  = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("t6_stay_vld",  vldA,  0);
        checkOutput("t6_stay_idle", idleA, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
